// File: rtl/sum_serial_nibble.sv
// Serial WIDTH-bit adder: one 4-bit nibble per clock, LSB nibble first, with the carry
// registered between nibbles. Operands are latched on start; o_done pulses when results update.
module sum_serial_nibble #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_bit1,
    input  logic [WIDTH-1:0] i_bit2,
    input  logic             i_Carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_Suma,
    output logic             o_Carry,
    output logic             o_overflow
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   partial_q, partial_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   suma_q, suma_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CNT_W+1:0]   nib_base;
    logic [4:0]         nib_sum;

    // Shared nibble adder: selected operand nibbles plus the carry register.
    always_comb begin
        nib_base = {cnt_q, 2'b00};
        nib_sum  = 5'(a_q[nib_base +: 4]) + 5'(b_q[nib_base +: 4]) + 5'(carry_q);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        suma_d    = suma_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    a_d       = i_bit1;
                    b_d       = i_bit2;
                    carry_d   = i_Carry;
                    partial_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                busy_d                   = 1'b1;
                partial_d[nib_base +: 4] = nib_sum[3:0];
                carry_d                  = nib_sum[4];
                if (cnt_q == LAST_CNT) begin
                    suma_d  = partial_d;
                    cout_d  = nib_sum[4];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (partial_d[WIDTH-1] != a_q[WIDTH-1]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register update; reset wins over any start in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            suma_q    <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            suma_q    <= suma_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_Suma     = suma_q;
    assign o_Carry    = cout_q;
    assign o_overflow = ovf_q;

endmodule
